// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit_deser serial receiver.
package bit_deser_pkg;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      CSUM = 2'd3
   } state_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [7:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/bit_deser_fifo.sv
// deser_fifo: first-word-fall-through FIFO of fifo_entry_t.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module deser_fifo
   import bit_deser_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  fifo_entry_t entry_i,
   input  logic        pop_i,
   output fifo_entry_t head_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   // Entry storage; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= entry_i;
   end

endmodule

// File: rtl/bit_deser.sv
// bit_deser: MSB-first serial receiver. Hunts for a sync byte, reads a length
// byte, then packs payload bytes with SOP/EOP into an output FWFT FIFO.
// Optional macro BIT_DESER_CHECKSUM_EN adds a trailing XOR checksum byte
// (CSUM state) and the crc_err_o pulse output.
module bit_deser
   import bit_deser_pkg::*;
#(
   parameter logic [7:0]  SYNC_WORD  = SYNC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_i,
   input  logic       bit_valid_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       sop_o,
   output logic       eop_o,
   output logic [7:0] len_o,
   output logic       busy_o,
   output logic       frame_done_o,
   output logic       len_err_o,
   output logic       ovf_o,
   input  logic       ovf_clr_i
`ifdef BIT_DESER_CHECKSUM_EN
   ,
   output logic       crc_err_o
`endif
);

   state_e      state_q, state_d;
   logic [7:0]  sr_q, sr_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  len_q, len_d;
   logic        first_q, first_d;
   logic        frame_done_q, frame_done_d;
   logic        len_err_q, len_err_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  byte_in;
   logic        last_bit;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   fifo_entry_t push_entry;
   fifo_entry_t head;
`ifdef BIT_DESER_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
   logic        crc_err_q, crc_err_d;
`endif

   assign byte_in  = {sr_q[6:0], bit_i};
   assign last_bit = (bit_cnt_q == 3'd7);
   assign pop      = valid_o && ready_i;

   // Next-state logic: everything advances only on a qualified bit.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      rem_d        = rem_q;
      len_d        = len_q;
      first_d      = first_q;
      frame_done_d = 1'b0;
      len_err_d    = 1'b0;
      push         = 1'b0;
      push_entry   = '{sop: first_q, eop: (rem_q == 8'd1), data: byte_in};
`ifdef BIT_DESER_CHECKSUM_EN
      csum_d       = csum_q;
      crc_err_d    = 1'b0;
`endif
      if (bit_valid_i) begin
         sr_d      = byte_in;
         bit_cnt_d = bit_cnt_q + 3'd1;
         unique case (state_q)
            HUNT: begin
               if (byte_in == SYNC_WORD) begin
                  state_d   = LEN;
                  bit_cnt_d = '0;
               end
            end
            LEN: begin
               if (last_bit) begin
                  if (byte_in == '0) begin
                     len_err_d = 1'b1;
                     state_d   = HUNT;
                  end else begin
                     len_d   = byte_in;
                     rem_d   = byte_in;
                     first_d = 1'b1;
                     state_d = DATA;
`ifdef BIT_DESER_CHECKSUM_EN
                     csum_d  = byte_in;
`endif
                  end
               end
            end
            DATA: begin
               if (last_bit) begin
                  push    = 1'b1;
                  first_d = 1'b0;
                  rem_d   = rem_q - 8'd1;
`ifdef BIT_DESER_CHECKSUM_EN
                  csum_d  = csum_q ^ byte_in;
                  if (rem_q == 8'd1) state_d = CSUM;
`else
                  if (rem_q == 8'd1) begin
                     frame_done_d = 1'b1;
                     state_d      = HUNT;
                  end
`endif
               end
            end
            CSUM: begin
`ifdef BIT_DESER_CHECKSUM_EN
               if (last_bit) begin
                  crc_err_d    = (byte_in != csum_q);
                  frame_done_d = 1'b1;
                  state_d      = HUNT;
               end
`else
               state_d = HUNT;
`endif
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear wins.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr_i)               ovf_d = 1'b0;
      if (push && full && !pop)    ovf_d = 1'b1;
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         rem_q        <= '0;
         len_q        <= '0;
         first_q      <= 1'b0;
         frame_done_q <= 1'b0;
         len_err_q    <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         rem_q        <= rem_d;
         len_q        <= len_d;
         first_q      <= first_d;
         frame_done_q <= frame_done_d;
         len_err_q    <= len_err_d;
         ovf_q        <= ovf_d;
      end
   end

`ifdef BIT_DESER_CHECKSUM_EN
   // Running checksum and its error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q    <= '0;
         crc_err_q <= 1'b0;
      end else begin
         csum_q    <= csum_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign crc_err_o = crc_err_q;
`endif

   deser_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign valid_o      = !empty;
   assign data_o       = empty ? '0 : head.data;
   assign sop_o        = !empty && head.sop;
   assign eop_o        = !empty && head.eop;
   assign len_o        = len_q;
   assign busy_o       = (state_q != HUNT);
   assign frame_done_o = frame_done_q;
   assign len_err_o    = len_err_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_bit_deser.sv
// Self-checking bench for bit_deser: directed frames plus random frames,
// checked against a frame-level model of what the output FIFO must deliver.
module tb_bit_deser;

   localparam int unsigned DEPTH = 4;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       bit_i;
   logic       bit_valid_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;
   logic       sop_o;
   logic       eop_o;
   logic [7:0] len_o;
   logic       busy_o;
   logic       frame_done_o;
   logic       len_err_o;
   logic       ovf_o;
   logic       ovf_clr_i;
`ifdef BIT_DESER_CHECKSUM_EN
   logic       crc_err_o;
`endif

   bit_deser #(
      .SYNC_WORD  (8'hA5),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .sop_o        (sop_o),
      .eop_o        (eop_o),
      .len_o        (len_o),
      .busy_o       (busy_o),
      .frame_done_o (frame_done_o),
      .len_err_o    (len_err_o),
      .ovf_o        (ovf_o),
      .ovf_clr_i    (ovf_clr_i)
`ifdef BIT_DESER_CHECKSUM_EN
      ,
      .crc_err_o    (crc_err_o)
`endif
   );

   always #5 clk = ~clk;

   int unsigned checks     = 0;
   int unsigned errors     = 0;
   int unsigned done_cnt   = 0;
   int unsigned lenerr_cnt = 0;
   int unsigned crcerr_cnt = 0;
   int unsigned exp_done   = 0;
   int          bit_idx    = 0;
   int          raise_at   = -1;
   ent_t        exp_q[$];
   ent_t        got_q[$];

   // Output monitor: records every accepted byte and counts pulses.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o && ready_i) got_q.push_back('{d: data_o, sop: sop_o, eop: eop_o});
         if (frame_done_o) done_cnt++;
         if (len_err_o)    lenerr_cnt++;
`ifdef BIT_DESER_CHECKSUM_EN
         if (crc_err_o)    crcerr_cnt++;
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit gap);
      if (gap) begin
         bit_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      if (bit_idx == raise_at) ready_i = 1'b1;
      bit_i       = b;
      bit_valid_i = 1'b1;
      tick();
      bit_valid_i = 1'b0;
      bit_idx++;
   endtask

   task automatic send_byte(input logic [7:0] v, input bit gap);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
   endtask

   // Idle zero byte, optional 1,0,1 misalignment, sync, length, payload
   // and (when enabled) a correct checksum byte.
   task automatic send_frame(input byte_q_t pl, input bit gap, input bit pre101);
      logic [7:0] cs;
      bit_idx = 0;
      cs = 8'(pl.size());
      send_byte(8'h00, gap);
      if (pre101) begin
         send_bit(1'b1, gap);
         send_bit(1'b0, gap);
         send_bit(1'b1, gap);
      end
      send_byte(8'hA5, gap);
      send_byte(8'(pl.size()), gap);
      foreach (pl[i]) begin
         send_byte(pl[i], gap);
         cs = cs ^ pl[i];
      end
`ifdef BIT_DESER_CHECKSUM_EN
      send_byte(cs, gap);
`endif
   endtask

   // Frame-level model: payload bytes in order, first flagged SOP, last EOP;
   // only `room` of them fit while nobody is draining.
   task automatic model_frame(input byte_q_t pl, input int room);
      int left;
      left = room;
      foreach (pl[i]) begin
         if (left > 0) begin
            exp_q.push_back('{d: pl[i], sop: (i == 0), eop: (i == pl.size() - 1)});
            left--;
         end
      end
   endtask

   task automatic drain_compare(input string tag);
      int n;
      ready_i = 1'b1;
      repeat (2) tick();
      n = 0;
      while (valid_o && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_drain_done"}, {31'd0, valid_o}, 32'd0);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i),
               {22'd0, got_q[i].sop, got_q[i].eop, got_q[i].d},
               {22'd0, exp_q[i].sop, exp_q[i].eop, exp_q[i].d});
      exp_q.delete();
      got_q.delete();
   endtask

   initial begin
      byte_q_t pl;
      rst_n       = 1'b0;
      bit_i       = 1'b0;
      bit_valid_i = 1'b0;
      ready_i     = 1'b1;
      ovf_clr_i   = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o},  32'd0);
      check("rst_len",   {24'd0, len_o},   32'd0);
      check("rst_ovf",   {31'd0, ovf_o},   32'd0);
      check("rst_pulses", {30'd0, frame_done_o, len_err_o}, 32'd0);
      check("rst_data",  {24'd0, data_o},  32'd0);
      rst_n = 1'b1;
      tick();

      // Nominal frame
      pl = '{8'h11, 8'h22, 8'h33};
      model_frame(pl, 1000);
      send_frame(pl, 1'b0, 1'b0);
      exp_done++;
      drain_compare("nominal");
      check("nominal_len",  {24'd0, len_o}, 32'd3);
      check("nominal_done", done_cnt, exp_done);
      check("nominal_ovf",  {31'd0, ovf_o}, 32'd0);
      check("nominal_busy", {31'd0, busy_o}, 32'd0);

      // Sync found off a byte boundary, single-byte frame
      pl = '{8'h7E};
      model_frame(pl, 1000);
      send_frame(pl, 1'b0, 1'b1);
      exp_done++;
      drain_compare("unaligned");
      check("unaligned_len", {24'd0, len_o}, 32'd1);

      // Zero length then a good frame
      bit_idx = 0;
      send_byte(8'h00, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      tick();
      check("zero_lenerr", lenerr_cnt, 32'd1);
      check("zero_busy",   {31'd0, busy_o},  32'd0);
      check("zero_nopush", {31'd0, valid_o}, 32'd0);
      pl = '{8'hC3};
      model_frame(pl, 1000);
      send_frame(pl, 1'b0, 1'b0);
      exp_done++;
      drain_compare("after_zero");

      // Sync value inside the payload is plain data
      pl = '{8'hA5, 8'hA5};
      model_frame(pl, 1000);
      send_frame(pl, 1'b0, 1'b0);
      exp_done++;
      drain_compare("embedded_sync");
      check("embedded_len", {24'd0, len_o}, 32'd2);

      // Overflow: consumer stalled, only DEPTH bytes survive
      ready_i = 1'b0;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      model_frame(pl, DEPTH);
      send_frame(pl, 1'b0, 1'b0);
      exp_done++;
      repeat (2) tick();
      check("ovf_set",  {31'd0, ovf_o}, 32'd1);
      check("ovf_head", {22'd0, sop_o, eop_o, data_o}, {22'd0, 2'b10, 8'h01});
      check("ovf_done", done_cnt, exp_done);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      check("ovf_clr", {31'd0, ovf_o}, 32'd0);
      drain_compare("overflow");

      // Gapped bits deliver the same bytes
      pl = '{8'hAA, 8'h55};
      model_frame(pl, 1000);
      send_frame(pl, 1'b1, 1'b0);
      exp_done++;
      drain_compare("gapped");

      // Push into a full FIFO with a pop in the same cycle: nothing lost.
      // Bit 63 is the last bit of the fifth payload byte.
      ready_i = 1'b0;
      pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
      model_frame(pl, 1000);
      raise_at = 63;
      send_frame(pl, 1'b0, 1'b0);
      raise_at = -1;
      exp_done++;
      drain_compare("full_pushpop");
      check("full_pushpop_ovf", {31'd0, ovf_o}, 32'd0);

      // Random frames with random gaps
      for (int f = 0; f < 6; f++) begin
         pl.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) pl.push_back(8'($urandom));
         model_frame(pl, 1000);
         send_frame(pl, 1'($urandom_range(0, 1)), 1'b0);
         exp_done++;
         drain_compare($sformatf("rand%0d", f));
         check($sformatf("rand%0d_len", f), {24'd0, len_o}, pl.size());
      end
      check("done_total", done_cnt, exp_done);

      // Reset in the middle of a frame
      ready_i = 1'b0;
      bit_idx = 0;
      send_byte(8'h00, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h04, 1'b0);
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      tick();
      check("midrst_pre_valid", {31'd0, valid_o}, 32'd1);
      check("midrst_pre_busy",  {31'd0, busy_o},  32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", {31'd0, valid_o}, 32'd0);
      check("midrst_busy",  {31'd0, busy_o},  32'd0);
      check("midrst_len",   {24'd0, len_o},   32'd0);
      tick();
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      tick();
      pl = '{8'h9C, 8'h3E};
      model_frame(pl, 1000);
      send_frame(pl, 1'b0, 1'b0);
      exp_done++;
      drain_compare("after_rst");

`ifdef BIT_DESER_CHECKSUM_EN
      // Wrong checksum: payload still delivered, error pulse raised
      check("crc_none_yet", crcerr_cnt, 32'd0);
      bit_idx = 0;
      pl = '{8'h10, 8'h20};
      model_frame(pl, 1000);
      send_byte(8'h00, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      tick();
      check("crc_err", crcerr_cnt, 32'd1);
      drain_compare("crc_frame");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_deser.md
Name: bit_deser

Overview:
- Single-clock serial-to-parallel receiver directly downstream of oserdes.
- Consumes the MSB-first bit stream (bit_o) one bit per qualified clock, hunts for a sync byte, reads a length byte, then packs payload bytes.
- Pushes bytes with SOP/EOP markers into a small first-word-fall-through FIFO with a valid/ready output.
- Serial side has no backpressure; the FIFO absorbs consumer stalls.

Parameters:
- SYNC_WORD, 8'hA5, frame sync byte matched in HUNT.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  receive clock.
- rst_n  input  1  reset; asynchronous, active-low.
- bit_i  input  1  serial data, MSB first.
- bit_valid_i  input  1  bit_i is sampled only when high.
- data_o  output  8  payload byte at FIFO head.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts; pop when valid_o && ready_i.
- sop_o  output  1  head byte is first of frame.
- eop_o  output  1  head byte is last of frame.
- len_o  output  8  length of current/last frame, held until next LEN capture.
- busy_o  output  1  state != HUNT.
- frame_done_o  output  1  one-cycle pulse, last payload byte collected.
- len_err_o  output  1  one-cycle pulse, LEN==0 received.
- ovf_o  output  1  sticky; byte dropped because FIFO full.
- ovf_clr_i  input  1  clears ovf_o. A same-cycle new drop wins.

Behaviour:
- Reset (async assert, sync release): state=HUNT; shift register and counters 0; FIFO empty; all outputs 0, len_o=0.
- Shift: on each bit_valid_i, sr <= {sr[6:0], bit_i}. bit_cnt counts 0..7 and wraps.
- HUNT: compare {sr[6:0],bit_i}==SYNC_WORD on every valid bit (sliding, not byte-aligned). On match, go to LEN with bit_cnt=0.
- LEN: after 8 valid bits, byte==0 gives len_err_o pulse and returns to HUNT. Otherwise len_o<=byte, byte_rem<=byte, go to DATA.
- DATA: after each 8th valid bit, push {sop=(first byte), eop=(byte_rem==1), byte} and decrement byte_rem.
  - On the eop byte: frame_done_o pulse, then go to HUNT (or CSUM if enabled).
- Push latency: the byte is written the cycle its 8th bit is sampled; valid_o/data_o are visible the next cycle.
- Full FIFO with push and no pop: byte is dropped, ovf_o<=1. The frame still advances (counters, eop, frame_done_o).
- Full FIFO with simultaneous push and pop: both occur and nothing is dropped.
- Empty FIFO: push and pop in the same cycle is impossible, because valid_o is low.
- Gaps: bit_valid_i low stalls all state; no timeout.
- bit_valid_i is ignored for sync in non-HUNT states. An embedded A5 in the payload is data.
- Reset mid-frame: FIFO flushed, partial frame lost.

Optional Feature:
- Macro BIT_DESER_CHECKSUM_EN.
- Defined:
  - Extra state CSUM after DATA.
  - Receives one byte; compares it to the XOR of the LEN byte and all payload bytes.
  - Mismatch drives crc_err_o (extra output port, 1-cycle pulse) the cycle after the checksum's 8th bit.
  - frame_done_o is moved to the same cycle.
  - The checksum byte is never pushed.
- Undefined: no CSUM state, no crc_err_o port, frame ends on the eop byte.

Decomposition:
- Package bit_deser_pkg:
  - state enum {HUNT, LEN, DATA, CSUM}.
  - SYNC_DEFAULT=8'hA5.
  - packed struct fifo_entry_t {sop, eop, data[7:0]}.
- Sub-module deser_fifo:
  - Synchronous FWFT FIFO of fifo_entry_t, parameter DEPTH.
  - Ports full/empty/push/pop.
  - Async active-low reset.

Test Plan:
- Nominal: bits of A5,03,11,22,33 with ready_i=1 → data_o 11(sop),22,33(eop); len_o=3; frame_done_o once; ovf_o=0.
- Unaligned sync: stream 1,0,1 then A5,01,7E → sync found mid-stream; single byte 7E with sop=eop=1.
- Zero length: A5,00 → len_err_o pulse, no push, busy_o=0. A following A5,01,C3 → C3 delivered.
- Overflow: ready_i=0, frame A5,06,01..06 with DEPTH=4 → bytes 01..04 stored, 05/06 dropped, ovf_o=1. ovf_clr_i pulse → 0.
- Gapped bits: bit_valid_i toggled 1/0 during A5,02,AA,55 → same output as ungapped. Push also with full FIFO and pop same cycle → no drop.
- Reset mid-frame: assert rst_n low after 2nd payload byte → valid_o=0, state=HUNT. With checksum enabled, A5,02,10,20, csum 30 (wrong, expected 32) → crc_err_o pulse.
